// File: rtl/mem_port_arbiter.sv
// Arbitrates icache read, dcache read and dcache write onto the single memory port, one beat per grant.
// Optional grant watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 64,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   ic_raddr_i,
  input  logic                ic_raddr_valid_i,
  input  logic [DATA_W/8-1:0] ic_rmask_i,
  output logic                ic_rdata_ready_o,
  output logic [DATA_W-1:0]   ic_rdata_o,
  input  logic [ADDR_W-1:0]   dc_raddr_i,
  input  logic                dc_raddr_valid_i,
  input  logic [DATA_W/8-1:0] dc_rmask_i,
  output logic                dc_rdata_ready_o,
  output logic [DATA_W-1:0]   dc_rdata_o,
  input  logic [ADDR_W-1:0]   dc_waddr_i,
  input  logic                dc_waddr_valid_i,
  input  logic [DATA_W/8-1:0] dc_wmask_i,
  input  logic [DATA_W-1:0]   dc_wdata_i,
  output logic                dc_wdata_ready_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic                mem_valid_o,
  output logic                mem_write_o,
  output logic [DATA_W/8-1:0] mem_mask_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic                mem_ready_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic                mem_timeout_o
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] GNT_IC_R = 2'd1;
  localparam logic [1:0] GNT_DC_R = 2'd2;
  localparam logic [1:0] GNT_DC_W = 2'd3;

  logic [1:0]          state;
  logic [1:0]          next_grant;
  logic                fair;
  logic                done;
  logic                timeout_hit;
  logic [DATA_W-1:0]   resp_data;
  logic [DATA_W-1:0]   ic_rdata_q;
  logic [DATA_W-1:0]   dc_rdata_q;
  logic [ADDR_W-1:0]   gnt_addr;
  logic [DATA_W/8-1:0] gnt_mask;
  logic [DATA_W-1:0]   gnt_wdata;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W =
    ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] wd_cnt;
  logic             timeout_q;

  // Fires in the TIMEOUT_CYCLES-th granted cycle unless memory answers in that same cycle.
  assign timeout_hit = (state != IDLE) && !mem_ready_i &&
                       (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign mem_timeout_o = timeout_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state == IDLE) wd_cnt <= '0;
      else               wd_cnt <= wd_cnt + 1'b1;
      if (timeout_hit) timeout_q <= 1'b1;
    end
  end
`else
  assign timeout_hit   = 1'b0;
  assign mem_timeout_o = 1'b0;
`endif

  // Reset suppresses the ready pulse of an aborted beat.
  assign done      = (state != IDLE) && !rst && (mem_ready_i || timeout_hit);
  assign resp_data = timeout_hit ? '0 : mem_rdata_i;

  assign ic_rdata_ready_o = done && (state == GNT_IC_R);
  assign dc_rdata_ready_o = done && (state == GNT_DC_R);
  assign dc_wdata_ready_o = done && (state == GNT_DC_W);
  assign ic_rdata_o = ic_rdata_ready_o ? resp_data : ic_rdata_q;
  assign dc_rdata_o = dc_rdata_ready_o ? resp_data : dc_rdata_q;

  always_comb begin
    next_grant = IDLE;
    gnt_addr   = '0;
    gnt_mask   = '0;
    gnt_wdata  = '0;
    if (fair && ic_raddr_valid_i)  next_grant = GNT_IC_R;
    else if (dc_waddr_valid_i)     next_grant = GNT_DC_W;
    else if (dc_raddr_valid_i)     next_grant = GNT_DC_R;
    else if (ic_raddr_valid_i)     next_grant = GNT_IC_R;
    case (next_grant)
      GNT_IC_R: begin
        gnt_addr = ic_raddr_i;
        gnt_mask = ic_rmask_i;
      end
      GNT_DC_R: begin
        gnt_addr = dc_raddr_i;
        gnt_mask = dc_rmask_i;
      end
      GNT_DC_W: begin
        gnt_addr  = dc_waddr_i;
        gnt_mask  = dc_wmask_i;
        gnt_wdata = dc_wdata_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      fair        <= 1'b0;
      mem_valid_o <= 1'b0;
      mem_write_o <= 1'b0;
      mem_addr_o  <= '0;
      mem_mask_o  <= '0;
      mem_wdata_o <= '0;
      ic_rdata_q  <= '0;
      dc_rdata_q  <= '0;
    end else if (state == IDLE) begin
      if (next_grant != IDLE) begin
        state       <= next_grant;
        mem_valid_o <= 1'b1;
        mem_write_o <= (next_grant == GNT_DC_W);
        mem_addr_o  <= gnt_addr;
        mem_mask_o  <= gnt_mask;
        mem_wdata_o <= gnt_wdata;
        if (next_grant == GNT_IC_R) fair <= 1'b0;
      end
    end else if (done) begin
      state       <= IDLE;
      mem_valid_o <= 1'b0;
      if (state == GNT_IC_R) ic_rdata_q <= resp_data;
      if (state == GNT_DC_R) dc_rdata_q <= resp_data;
      // A dcache beat finishing while the icache waits gives the icache the next grant.
      if (state != GNT_IC_R && ic_raddr_valid_i) fair <= 1'b1;
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single core memory port between three requesters: icache read, dcache read and dcache write.
- Sits between the icache/dcache ram-side ports and the memory bridge (DPI ram / AXI shim). Each requester uses the valid-hold / ready-pulse handshake of the cache ram ports.
- Serialises one 64-bit beat per grant, registers all downstream request signals, and routes the response back to the granted requester only.

Parameters:
- ADDR_W, 32, address width, equal to `NPC_ADDR_BUS.
- DATA_W, 64, data width, equal to `XLEN_BUS.
- TIMEOUT_CYCLES, 256, watchdog limit in cycles; used only with MEM_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ic_raddr_i  in  32  icache read address
- ic_raddr_valid_i  in  1  icache read request
- ic_rmask_i  in  8  icache read byte mask
- ic_rdata_ready_o  out  1  icache read done pulse
- ic_rdata_o  out  64  icache read data
- dc_raddr_i  in  32  dcache read address
- dc_raddr_valid_i  in  1  dcache read request
- dc_rmask_i  in  8  dcache read mask
- dc_rdata_ready_o  out  1  dcache read done pulse
- dc_rdata_o  out  64  dcache read data
- dc_waddr_i  in  32  dcache write address
- dc_waddr_valid_i  in  1  dcache write request
- dc_wmask_i  in  8  dcache write mask
- dc_wdata_i  in  64  dcache write data
- dc_wdata_ready_o  out  1  dcache write done pulse
- mem_addr_o  out  32  downstream address
- mem_valid_o  out  1  downstream request
- mem_write_o  out  1  1 = write, 0 = read
- mem_mask_o  out  8  downstream byte mask
- mem_wdata_o  out  64  downstream write data
- mem_ready_i  in  1  downstream done pulse
- mem_rdata_i  in  64  downstream read data
- mem_timeout_o  out  1  sticky watchdog flag

Behaviour:
- Clock is clk; reset is rst, synchronous, active-high.
- Reset values: state IDLE; mem_valid_o, mem_write_o, mem_timeout_o = 0; mem_addr_o, mem_mask_o, mem_wdata_o = 0; icache fairness flag = 0.
- States: IDLE, GNT_IC_R, GNT_DC_R, GNT_DC_W.
- Arbitration in IDLE, evaluated on the inputs of the current cycle:
  - dc write beats dc read, which beats ic read.
  - Exception: if the fairness flag is set and ic_raddr_valid_i is high, the icache wins. The flag sets when a dcache grant completes while ic_raddr_valid_i is high; it clears on any icache grant.
- On grant (registered at the next edge):
  - Latch the winner's address, mask and wdata into mem_*_o.
  - Set mem_valid_o = 1.
  - Set mem_write_o = 1 for GNT_DC_W only.
- Granted state holds mem_* stable until mem_ready_i = 1.
- In the mem_ready_i cycle:
  - The granted requester's ready output = 1, combinational pass-through from mem_ready_i.
  - The granted requester's rdata = mem_rdata_i. Non-granted readys = 0; their rdata holds the last value.
  - Next edge: mem_valid_o = 0, state IDLE.
- Latency: requester valid at cycle t → mem_valid_o at t+1 → requester ready in the same cycle as mem_ready_i. Minimum t+1 for a zero-wait memory.
- IDLE lasts at least 1 cycle between grants, so mem_valid_o drops for ≥1 cycle per beat. Multi-beat dcache line fills re-arbitrate between beats, and the icache may interleave when the fairness flag is set.
- A requester dropping valid while granted is a protocol error. The arbiter still completes the beat and forwards the ready pulse.
- dc_raddr_valid_i and dc_waddr_valid_i high together: the write is served first, then the read.
- mem_ready_i in IDLE is ignored; no requester ready is asserted.
- rst mid-transaction aborts the beat: state IDLE, no ready pulse emitted, fairness flag cleared.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Enabled:
  - An 8+ bit counter counts cycles in any GNT state and clears on entry to IDLE.
  - When the count reaches TIMEOUT_CYCLES without mem_ready_i, the arbiter pulses the granted requester's ready with rdata = 0, drops mem_valid_o, returns to IDLE, and sets mem_timeout_o = 1. mem_timeout_o stays 1 until rst.
- Disabled: no counter; mem_timeout_o tied to 0; a grant waits indefinitely.

Test Plan:
- IC read only, addr 0x8000_0000, memory ready 3 cycles after mem_valid_o, rdata 0x0000_0013_0000_0093 → mem_addr_o = 0x8000_0000, mem_write_o = 0; ic_rdata_ready_o a single pulse with the same data; dc_rdata_ready_o stays 0.
- IC read and DC read raised in the same cycle (0x8000_0100 / 0x8000_2000) → DC granted first; fairness flag set; the next grant goes to IC even with DC still requesting.
- DC write addr 0x8000_3008, mask 0x0F, wdata 0xDEAD_BEEF → mem_write_o = 1, mem_mask_o = 0x0F, mem_wdata_o = 0xDEAD_BEEF; dc_wdata_ready_o pulses; no read ready pulses.
- DC read and write valid together → write beat completes, mem_valid_o low ≥1 cycle, then read beat.
- rst asserted 2 cycles into a GNT_DC_R wait → next cycle mem_valid_o = 0, state IDLE; no dc_rdata_ready_o pulse; a later ic request is granted normally.
- MEM_ARB_TIMEOUT_EN with TIMEOUT_CYCLES = 16 and memory never ready → ic_rdata_ready_o pulses with data 0 after 16 granted cycles; mem_timeout_o = 1 and stays 1 until rst.
